// File: rtl/n64_vdemux_pkg.sv
// Shared types and constants for the N64 video bus demultiplexer.
// The state encoding and the sync nibble layout are defined here once.
package n64_vdemux_pkg;

    localparam int COLOR_W_DEF   = 7;
    localparam int ERR_CNT_W_DEF = 8;
    localparam int SYNC_W        = 4;

    // Position of each sync line in the nibble {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
    localparam int VSYNC_BIT = 3;
    localparam int CLAMP_BIT = 2;
    localparam int HSYNC_BIT = 1;
    localparam int CSYNC_BIT = 0;

    // All syncs are active low, so all-ones means "no sync asserted"
    localparam logic [SYNC_W-1:0] SYNC_IDLE = 4'hF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_R    = 3'd1,
        ST_G    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic int vdata_width(input int cw);
        return SYNC_W + 3 * cw;
    endfunction

endpackage

// File: rtl/n64_vdemux_if.sv
// Multiplexed video bus plus demultiplexed outputs and error reporting.
// The master drives the bus (video source), the slave is the demultiplexer.
interface n64_vdemux_if
    import n64_vdemux_pkg::*;
#(
    parameter int CW = COLOR_W_DEF,
    parameter int EW = ERR_CNT_W_DEF
);
    logic                       nDSYNC;
    logic [CW-1:0]              D_i;
    logic                       err_clr_i;
    logic [SYNC_W-1:0]          Sync_pre;
    logic [SYNC_W-1:0]          Sync_cur;
    logic [SYNC_W+3*CW-1:0]     vdata_o;
    logic                       vdata_valid_o;
    logic                       err_o;
    logic [EW-1:0]              err_cnt_o;

    modport master (
        output nDSYNC, D_i, err_clr_i,
        input  Sync_pre, Sync_cur, vdata_o, vdata_valid_o, err_o, err_cnt_o
    );

    modport slave (
        input  nDSYNC, D_i, err_clr_i,
        output Sync_pre, Sync_cur, vdata_o, vdata_valid_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/n64_vdemux.sv
// Demultiplexes the 4-phase N64 video bus (sync,R,G,B) into parallel words,
// tracks the sync nibble history and counts group misalignments.
module n64_vdemux
    import n64_vdemux_pkg::*;
#(
    parameter int color_width_i = COLOR_W_DEF,
    parameter int ERR_CNT_W     = ERR_CNT_W_DEF
) (
    input  logic          VCLK,
    input  logic          RST,
    n64_vdemux_if.slave   bus
);
    localparam int VW = vdata_width(color_width_i);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    state_t                   state_q, state_d;
    logic [color_width_i-1:0] r_q, r_d, g_q, g_d;
    logic [SYNC_W-1:0]        hold_q, hold_d, pre_q, pre_d, cur_q, cur_d;
    logic [VW-1:0]            vdata_q, vdata_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_W-1:0]     cnt_q, cnt_d;
    logic [SYNC_W-1:0]        sync_in;
    logic                     misalign;

    assign sync_in = {bus.D_i[VSYNC_BIT], bus.D_i[CLAMP_BIT],
                      bus.D_i[HSYNC_BIT], bus.D_i[CSYNC_BIT]};

    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            r_q     <= '0;
            g_q     <= '0;
            hold_q  <= SYNC_IDLE;
            pre_q   <= SYNC_IDLE;
            cur_q   <= SYNC_IDLE;
            vdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            g_q     <= g_d;
            hold_q  <= hold_d;
            pre_q   <= pre_d;
            cur_q   <= cur_d;
            vdata_q <= vdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // A sync phase restarts the group from any state
    always_comb begin
        state_d = state_q;
        if (!bus.nDSYNC) begin
            state_d = ST_R;
        end else begin
            unique case (state_q)
                ST_R:    state_d = ST_G;
                ST_G:    state_d = ST_B;
                ST_B:    state_d = ST_DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        r_d     = r_q;
        g_d     = g_q;
        hold_d  = hold_q;
        pre_d   = pre_q;
        cur_d   = cur_q;
        vdata_d = vdata_q;
        valid_d = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (!bus.nDSYNC) begin
            pre_d  = cur_q;
            cur_d  = sync_in;
            hold_d = sync_in;
        end else begin
            unique case (state_q)
                ST_R: r_d = bus.D_i;
                ST_G: g_d = bus.D_i;
                ST_B: begin
                    vdata_d = {hold_q, r_q, g_q, bus.D_i};
                    valid_d = 1'b1;
                end
                default: ;
            endcase
        end

        // Early sync mid-group, or a missing sync after a complete group
        misalign = bus.nDSYNC ? (state_q == ST_DONE)
                              : (state_q inside {ST_R, ST_G, ST_B});

        if (misalign) begin
            err_d = 1'b1;
            if (bus.err_clr_i)
                cnt_d = ERR_CNT_W'(1);
            else if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + ERR_CNT_W'(1);
        end else if (bus.err_clr_i) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
    end

    assign bus.Sync_pre      = pre_q;
    assign bus.Sync_cur      = cur_q;
    assign bus.vdata_o       = vdata_q;
    assign bus.vdata_valid_o = valid_q;
    assign bus.err_o         = err_q;
    assign bus.err_cnt_o     = cnt_q;

endmodule

// File: tb/tb_n64_vdemux.sv
// Directed bench for n64_vdemux: per-cycle vector table plus an
// asynchronous reset in the middle of a group.
module tb_n64_vdemux;
    localparam int CW = 7;
    localparam int EW = 2;
    localparam int VW = 4 + 3 * CW;

    typedef struct {
        logic          nd;
        logic [CW-1:0] d;
        logic          clr;
        logic          valid;
        logic [VW-1:0] vdata;
        logic [3:0]    pre;
        logic [3:0]    cur;
        logic          err;
        logic [EW-1:0] cnt;
    } vec_t;

    logic VCLK = 1'b0;
    logic RST  = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    n64_vdemux_if #(.CW(CW), .EW(EW)) bus ();

    n64_vdemux #(.color_width_i(CW), .ERR_CNT_W(EW)) dut (
        .VCLK (VCLK),
        .RST  (RST),
        .bus  (bus)
    );

    always #5 VCLK = ~VCLK;

    function automatic logic [VW-1:0] vd(input logic [3:0] s, input logic [CW-1:0] r,
                                         input logic [CW-1:0] g, input logic [CW-1:0] b);
        return {s, r, g, b};
    endfunction

    task automatic add(input logic nd, input logic [CW-1:0] d, input logic clr,
                       input logic valid, input logic [VW-1:0] vdata,
                       input logic [3:0] pre, input logic [3:0] cur,
                       input logic err, input logic [EW-1:0] cnt);
        vec_t v;
        v.nd = nd; v.d = d; v.clr = clr; v.valid = valid; v.vdata = vdata;
        v.pre = pre; v.cur = cur; v.err = err; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic valid, input logic [VW-1:0] vdata,
                             input logic [3:0] pre, input logic [3:0] cur,
                             input logic err, input logic [EW-1:0] cnt);
        check({tag, " valid"}, 32'(bus.vdata_valid_o), 32'(valid));
        check({tag, " vdata"}, 32'(bus.vdata_o), 32'(vdata));
        check({tag, " pre"},   32'(bus.Sync_pre), 32'(pre));
        check({tag, " cur"},   32'(bus.Sync_cur), 32'(cur));
        check({tag, " err"},   32'(bus.err_o), 32'(err));
        check({tag, " cnt"},   32'(bus.err_cnt_o), 32'(cnt));
    endtask

    // Drive one bus phase, clock it in, and leave time just after the edge
    task automatic cyc(input logic nd, input logic [CW-1:0] d, input logic clr);
        bus.nDSYNC    = nd;
        bus.D_i       = d;
        bus.err_clr_i = clr;
        @(posedge VCLK);
        #1;
    endtask

    initial begin
        logic [VW-1:0] va, vb, vc, vdd, ve;
        va  = vd(4'hF, 7'h11, 7'h22, 7'h33);
        vb  = vd(4'h7, 7'h11, 7'h22, 7'h33);
        vc  = vd(4'hF, 7'h44, 7'h55, 7'h66);
        vdd = vd(4'hF, 7'h01, 7'h02, 7'h03);
        ve  = vd(4'hF, 7'h0A, 7'h0B, 7'h0C);

        // nominal groups
        add(0, 7'h0F, 0, 0, '0,  4'hF, 4'hF, 0, 0);
        add(1, 7'h11, 0, 0, '0,  4'hF, 4'hF, 0, 0);
        add(1, 7'h22, 0, 0, '0,  4'hF, 4'hF, 0, 0);
        add(1, 7'h33, 0, 1, va,  4'hF, 4'hF, 0, 0);
        add(0, 7'h0F, 0, 0, va,  4'hF, 4'hF, 0, 0);
        add(1, 7'h11, 0, 0, va,  4'hF, 4'hF, 0, 0);
        add(1, 7'h22, 0, 0, va,  4'hF, 4'hF, 0, 0);
        add(1, 7'h33, 0, 1, va,  4'hF, 4'hF, 0, 0);
        // nVSYNC falls, then stays low
        add(0, 7'h07, 0, 0, va,  4'hF, 4'h7, 0, 0);
        add(1, 7'h11, 0, 0, va,  4'hF, 4'h7, 0, 0);
        add(1, 7'h22, 0, 0, va,  4'hF, 4'h7, 0, 0);
        add(1, 7'h33, 0, 1, vb,  4'hF, 4'h7, 0, 0);
        add(0, 7'h07, 0, 0, vb,  4'h7, 4'h7, 0, 0);
        add(1, 7'h11, 0, 0, vb,  4'h7, 4'h7, 0, 0);
        add(1, 7'h22, 0, 0, vb,  4'h7, 4'h7, 0, 0);
        add(1, 7'h33, 0, 1, vb,  4'h7, 4'h7, 0, 0);
        // early sync right after green
        add(0, 7'h0F, 0, 0, vb,  4'h7, 4'hF, 0, 0);
        add(1, 7'h11, 0, 0, vb,  4'h7, 4'hF, 0, 0);
        add(1, 7'h22, 0, 0, vb,  4'h7, 4'hF, 0, 0);
        add(0, 7'h0F, 0, 0, vb,  4'hF, 4'hF, 1, 1);
        add(1, 7'h44, 0, 0, vb,  4'hF, 4'hF, 1, 1);
        add(1, 7'h55, 0, 0, vb,  4'hF, 4'hF, 1, 1);
        add(1, 7'h66, 0, 1, vc,  4'hF, 4'hF, 1, 1);
        // sync missing for three cycles
        add(1, 7'h00, 0, 0, vc,  4'hF, 4'hF, 1, 2);
        add(1, 7'h7F, 0, 0, vc,  4'hF, 4'hF, 1, 2);
        add(1, 7'h7F, 0, 0, vc,  4'hF, 4'hF, 1, 2);
        add(0, 7'h0F, 0, 0, vc,  4'hF, 4'hF, 1, 2);
        add(1, 7'h01, 0, 0, vc,  4'hF, 4'hF, 1, 2);
        add(1, 7'h02, 0, 0, vc,  4'hF, 4'hF, 1, 2);
        add(1, 7'h03, 0, 1, vdd, 4'hF, 4'hF, 1, 2);
        // clear, then saturate the 2-bit counter
        add(0, 7'h0F, 1, 0, vdd, 4'hF, 4'hF, 0, 0);
        add(0, 7'h0F, 0, 0, vdd, 4'hF, 4'hF, 1, 1);
        add(0, 7'h0F, 0, 0, vdd, 4'hF, 4'hF, 1, 2);
        add(0, 7'h0F, 0, 0, vdd, 4'hF, 4'hF, 1, 3);
        add(0, 7'h0F, 0, 0, vdd, 4'hF, 4'hF, 1, 3);
        add(0, 7'h0F, 0, 0, vdd, 4'hF, 4'hF, 1, 3);
        // clear coincident with a misalignment: error wins
        add(0, 7'h0F, 1, 0, vdd, 4'hF, 4'hF, 1, 1);
        add(1, 7'h0A, 0, 0, vdd, 4'hF, 4'hF, 1, 1);
        add(1, 7'h0B, 0, 0, vdd, 4'hF, 4'hF, 1, 1);
        add(1, 7'h0C, 0, 1, ve,  4'hF, 4'hF, 1, 1);
        add(0, 7'h03, 1, 0, ve,  4'hF, 4'h3, 0, 0);

        bus.nDSYNC = 1'b1; bus.D_i = '0; bus.err_clr_i = 1'b0;
        repeat (2) @(posedge VCLK);
        #1;
        check_all("reset", 0, '0, 4'hF, 4'hF, 0, 0);
        RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].nd, vecs[i].d, vecs[i].clr);
            $display("vec %0d nd=%0b d=%02h clr=%0b -> valid=%0b vdata=%07h pre=%h cur=%h err=%0b cnt=%0d",
                     i, vecs[i].nd, vecs[i].d, vecs[i].clr, bus.vdata_valid_o, bus.vdata_o,
                     bus.Sync_pre, bus.Sync_cur, bus.err_o, bus.err_cnt_o);
            check_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].vdata,
                      vecs[i].pre, vecs[i].cur, vecs[i].err, vecs[i].cnt);
        end

        // asynchronous reset while the FSM waits for green
        cyc(1, 7'h11, 0);
        #2 RST = 1'b1;
        #1;
        $display("async reset mid-group -> valid=%0b vdata=%07h pre=%h cur=%h err=%0b cnt=%0d",
                 bus.vdata_valid_o, bus.vdata_o, bus.Sync_pre, bus.Sync_cur, bus.err_o, bus.err_cnt_o);
        check_all("rst_mid", 0, '0, 4'hF, 4'hF, 0, 0);
        #1 RST = 1'b0;
        cyc(1, 7'h22, 0);
        $display("post-reset g -> valid=%0b", bus.vdata_valid_o);
        check("rst_nostrobe_g", 32'(bus.vdata_valid_o), 32'd0);
        cyc(1, 7'h33, 0);
        $display("post-reset b -> valid=%0b", bus.vdata_valid_o);
        check_all("rst_nostrobe_b", 0, '0, 4'hF, 4'hF, 0, 0);
        cyc(0, 7'h0F, 0);
        cyc(1, 7'h11, 0);
        cyc(1, 7'h22, 0);
        check("rst_pre_b", 32'(bus.vdata_valid_o), 32'd0);
        cyc(1, 7'h33, 0);
        $display("post-reset group -> valid=%0b vdata=%07h", bus.vdata_valid_o, bus.vdata_o);
        check_all("rst_recover", 1, va, 4'hF, 4'hF, 0, 0);
        cyc(0, 7'h0F, 0);
        check("rst_strobe_1cyc", 32'(bus.vdata_valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/n64_vdemux.md
Name: n64_vdemux

Overview:
Upstream neighbour of n64_vinfo_ext. Demultiplexes the N64 7-bit time-multiplexed video bus (sync, R, G, B per 4-cycle group, group start flagged by nDSYNC low) into parallel pixel words. It supplies the registered Sync_pre/Sync_cur vectors that n64_vinfo_ext consumes, and a parallel pixel word with a valid strobe for the downstream video pipeline. It also detects and counts bus misalignment.

Parameters:
color_width_i, 7, width of each colour component and of D_i
ERR_CNT_W, 8, width of the saturating misalignment counter

Ports:
VCLK  in  1  video clock, all logic on rising edge
RST  in  1  asynchronous, active-high reset
nDSYNC  in  1  low = sync nibble on D_i, starts a pixel group
D_i  in  color_width_i  multiplexed video bus
Sync_pre  out  4  sync nibble of previous group {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
Sync_cur  out  4  sync nibble of current group, same order
vdata_o  out  4+3*color_width_i  {sync,R,G,B} of last complete group
vdata_valid_o  out  1  one-cycle strobe, vdata_o updated
err_o  out  1  sticky misalignment flag
err_clr_i  in  1  clears err_o and err_cnt_o
err_cnt_o  out  ERR_CNT_W  saturating misalignment count

Behaviour:
- Reset (async, RST=1): Sync_pre=Sync_cur=4'hF (syncs inactive, so no false edge in n64_vinfo_ext), vdata_o=0, vdata_valid_o=0, err_o=0, err_cnt_o=0, FSM=IDLE.
- FSM states: IDLE, ST_R, ST_G, ST_B, ST_DONE. Any cycle with nDSYNC=0, from any state: Sync_pre<=Sync_cur, Sync_cur<=D_i[3:0], sync_hold<=D_i[3:0], next=ST_R.
- nDSYNC=1 transitions: ST_R captures R<=D_i and goes to ST_G. ST_G captures G and goes to ST_B. ST_B captures B and goes to ST_DONE. IDLE stays in IDLE.
- Output timing: on the edge that captures B, vdata_o<={sync_hold,R,G,D_i} and vdata_valid_o<=1 at the same edge. vdata_o and vdata_valid_o are therefore visible in the cycle after the blue sample, which is 1-cycle latency. vdata_valid_o is 0 in all other cycles. vdata_o holds its value between strobes.
- Early group: nDSYNC=0 while FSM is in ST_R, ST_G or ST_B is a misalignment. The partial group is discarded with no strobe, and the new group starts normally.
- Lost group: nDSYNC=1 while in ST_DONE is a misalignment. FSM goes to IDLE, and no capture happens until the next nDSYNC=0.
- nDSYNC=0 in ST_DONE or IDLE is the nominal case, not an error. The first group after reset is therefore never flagged.
- On a misalignment: err_o<=1, and err_cnt_o increments, saturating at 2^ERR_CNT_W-1 with no wrap.
- err_clr_i=1: err_o<=0, err_cnt_o<=0. If a misalignment occurs in the same cycle, the error wins: err_o<=1, err_cnt_o<=1.
- Sync_pre/Sync_cur change only on nDSYNC=0 cycles. They hold otherwise, including during IDLE.
- RST mid-group: immediate clear to reset values. A partial group is never emitted.

Decomposition:
- n64rgb_params.vh holds: color_width_i default, sync nibble bit indices (vsync=3, clamp=2, hsync=1, csync=0), FSM state encodings, vdata_o width constant.
- Single flat module, no sub-module. The FSM and datapath are small.

Test Plan:
- Nominal: groups of nDSYNC=0 with D=0x0F, then R=0x11, G=0x22, B=0x33, repeated -> vdata_valid_o pulses every 4th cycle, one cycle after B, with vdata_o={4'hF,0x11,0x22,0x33}; err_o=0.
- Sync propagation: sync nibble changes 0xF->0x7 (nVSYNC falls) -> Sync_pre=0xF, Sync_cur=0x7 for exactly the following group; 0x7->0x7 gives Sync_pre=Sync_cur=0x7.
- Early nDSYNC after G -> no strobe for that group; err_o=1, err_cnt_o=1; the next full group emits normally.
- Missing nDSYNC after B for 3 cycles -> FSM in IDLE, no strobes; err_cnt_o+=1 once only; recovery on the next nDSYNC.
- Saturation with ERR_CNT_W=2: 5 misalignments -> err_cnt_o=3. Then err_clr_i coincident with a misalignment -> err_cnt_o=1, err_o=1.
- RST asserted in ST_G -> all outputs at reset values immediately, Sync_*=0xF; no strobe until a full group after RST is released.
